// File: rtl/heartbeat_framed.sv
// Frame-based heartbeat beacon: sync 1100, frame counter MSB-first, even parity, idle-low gap.
// Half-bit slot length is div+1 clocks; line code is Manchester (mode=0) or NRZ (mode=1).
module heartbeat_framed #(
   parameter int WIDTH     = 8,
   parameter int DIV_WIDTH = 8,
   parameter int GAP       = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ena,
   input  logic [DIV_WIDTH-1:0] div,
   input  logic                 mode,
   output logic                 signal,
   output logic                 frame_start,
   output logic                 busy,
   output logic [WIDTH-1:0]     count
);
   localparam int MAXSLOT = (WIDTH > GAP) ? 2 * WIDTH : 2 * GAP;
   localparam int SLOT_W  = $clog2(MAXSLOT + 1);
   localparam logic [SLOT_W-1:0] SYNC_LAST = SLOT_W'(3);
   localparam logic [SLOT_W-1:0] DATA_LAST = SLOT_W'(2 * WIDTH - 1);
   localparam logic [SLOT_W-1:0] PAR_LAST  = SLOT_W'(1);
   localparam logic [SLOT_W-1:0] GAP_LAST  = SLOT_W'(2 * GAP - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SYNC   = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_GAP    = 3'd4
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [SLOT_W-1:0]    r_slot, w_slot_nxt;
   logic [DIV_WIDTH-1:0] r_presc, w_presc_nxt;
   logic [WIDTH-1:0]     r_shift, w_shift_nxt;
   logic [WIDTH-1:0]     r_count, w_count_nxt;
   logic                 r_par, w_par_nxt;
   logic                 r_mode, w_mode_nxt;
   logic                 r_signal, w_signal_nxt;
   logic                 r_fs, w_fs_nxt;
   logic                 r_busy, w_busy_nxt;
   logic                 w_tick, w_last, w_bit;

   // The >= compare lets a lowered div end the current slot at once instead of wrapping.
   assign w_tick = (r_state != S_IDLE) && (r_presc >= div);

   // Last-slot flag for the active state.
   always_comb begin
      w_last = 1'b0;
      case (r_state)
         S_SYNC:   w_last = (r_slot == SYNC_LAST);
         S_DATA:   w_last = (r_slot == DATA_LAST);
         S_PARITY: w_last = (r_slot == PAR_LAST);
         S_GAP:    w_last = (r_slot == GAP_LAST);
         default:  w_last = 1'b0;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_slot  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_slot  <= w_slot_nxt;
      end
   end

   // Next-state and slot-index logic.
   always_comb begin
      w_state_nxt = r_state;
      w_slot_nxt  = r_slot;
      case (r_state)
         S_IDLE: begin
            w_slot_nxt = '0;
            if (ena) begin
               w_state_nxt = S_SYNC;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_SYNC, S_DATA, S_PARITY, S_GAP: begin
            if (w_tick && w_last) begin
               w_slot_nxt = '0;
               case (r_state)
                  S_SYNC:   w_state_nxt = S_DATA;
                  S_DATA:   w_state_nxt = S_PARITY;
                  S_PARITY: w_state_nxt = S_GAP;
                  default:  w_state_nxt = S_IDLE;
               endcase
            end else if (w_tick) begin
               w_slot_nxt = r_slot + SLOT_W'(1);
            end else begin
               w_slot_nxt = r_slot;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_slot_nxt  = '0;
         end
      endcase
   end

   // Datapath next values; the line value is derived from the state/slot being entered.
   always_comb begin
      w_presc_nxt = ((r_state == S_IDLE) || w_tick) ? '0 : r_presc + DIV_WIDTH'(1);
      w_shift_nxt = r_shift;
      w_par_nxt   = r_par;
      w_mode_nxt  = r_mode;
      w_count_nxt = r_count;
      if ((r_state == S_IDLE) && ena) begin
         w_shift_nxt = r_count;
         w_par_nxt   = 1'b0;
         w_mode_nxt  = mode;
      end else if ((r_state == S_DATA) && w_tick && r_slot[0]) begin
         w_shift_nxt = r_shift << 1;
         w_par_nxt   = r_par ^ r_shift[WIDTH-1];
      end else begin
         w_shift_nxt = r_shift;
      end
      if ((r_state == S_GAP) && w_tick && w_last) begin
         w_count_nxt = r_count + WIDTH'(1);
      end else begin
         w_count_nxt = r_count;
      end
      w_bit = w_shift_nxt[WIDTH-1];
      case (w_state_nxt)
         S_SYNC:   w_signal_nxt = (w_slot_nxt < SLOT_W'(2));
         S_DATA:   w_signal_nxt = (!w_slot_nxt[0] && !w_mode_nxt) ? ~w_bit : w_bit;
         S_PARITY: w_signal_nxt = (!w_slot_nxt[0] && !w_mode_nxt) ? ~w_par_nxt : w_par_nxt;
         default:  w_signal_nxt = 1'b0;
      endcase
      w_fs_nxt   = (r_state == S_IDLE) && ena;
      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc  <= '0;
         r_shift  <= '0;
         r_par    <= 1'b0;
         r_mode   <= 1'b0;
         r_count  <= '0;
         r_signal <= 1'b0;
         r_fs     <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_presc  <= w_presc_nxt;
         r_shift  <= w_shift_nxt;
         r_par    <= w_par_nxt;
         r_mode   <= w_mode_nxt;
         r_count  <= w_count_nxt;
         r_signal <= w_signal_nxt;
         r_fs     <= w_fs_nxt;
         r_busy   <= w_busy_nxt;
      end
   end

   assign signal      = r_signal;
   assign frame_start = r_fs;
   assign busy        = r_busy;
   assign count       = r_count;
endmodule

// File: tb/tb_heartbeat_framed.sv
// Scoreboard bench for heartbeat_framed (WIDTH=8, GAP=2): expected slot values are
// queued when a frame is launched and compared cycle by cycle as the line is sampled.
module tb_heartbeat_framed;
   localparam int NSLOT = 4 + 2 * (8 + 1) + 2 * 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] div;
   logic       mode;
   logic       signal;
   logic       frame_start;
   logic       busy;
   logic [7:0] count;

   logic       exp_q[$];
   logic [7:0] m_count;
   int         n_cmp = 0;
   int         n_mis = 0;

   heartbeat_framed #(.WIDTH(8), .DIV_WIDTH(8), .GAP(2)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .div(div), .mode(mode),
      .signal(signal), .frame_start(frame_start), .busy(busy), .count(count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Expected half-bit slot sequence for one frame.
   task automatic push_frame(input logic [7:0] p, input logic m);
      logic par;
      par = ^p;
      exp_q.push_back(1'b1); exp_q.push_back(1'b1);
      exp_q.push_back(1'b0); exp_q.push_back(1'b0);
      for (int i = 7; i >= 0; i--) begin
         exp_q.push_back(m ? p[i] : ~p[i]);
         exp_q.push_back(p[i]);
      end
      exp_q.push_back(m ? par : ~par);
      exp_q.push_back(par);
      for (int i = 0; i < 4; i++) exp_q.push_back(1'b0);
   endtask

   // Called at a negedge with the DUT idle; slot 0 is sampled c0 cycles, then div becomes d.
   task automatic run_frame(input int d0, input int c0, input int d, input logic m, input int drop_slot);
      logic e;
      int   len;
      div  = 8'(d0);
      mode = m;
      ena  = 1'b1;
      push_frame(m_count, m);
      for (int s = 0; s < NSLOT; s++) begin
         e   = exp_q.pop_front();
         len = (s == 0) ? c0 : d + 1;
         for (int c = 0; c < len; c++) begin
            @(negedge clk);
            check($sformatf("sig p%0h s%0d", m_count, s), 32'(signal), 32'(e));
            check("busy_in_frame", 32'(busy), 32'd1);
            check("frame_start", 32'(frame_start), 32'((s == 0) && (c == 0)));
            check("count_held", 32'(count), 32'(m_count));
         end
         if (s == 0) div = 8'(d);
         if (s == drop_slot) ena = 1'b0;
      end
      @(negedge clk);
      m_count = m_count + 8'd1;
      check("count_after", 32'(count), 32'(m_count));
      check("busy_after", 32'(busy), 32'd0);
      check("sig_after", 32'(signal), 32'd0);
      check("fs_after", 32'(frame_start), 32'd0);
   endtask

   initial begin
      rst_n   = 1'b0;
      ena     = 1'b0;
      div     = 8'd0;
      mode    = 1'b0;
      m_count = 8'd0;
      repeat (3) @(negedge clk);
      check("rst_sig", 32'(signal), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_fs", 32'(frame_start), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);

      // 256 back-to-back Manchester frames: covers 0x00, 0xA5 -> 0xA6 and the 0xFF -> 0x00 wrap.
      for (int f = 0; f < 256; f++) run_frame(0, 1, 0, 1'b0, -1);
      check("wrap_count", 32'(count), 32'd0);

      for (int f = 0; f < 3; f++) run_frame(0, 1, 0, 1'b0, -1);
      run_frame(0, 1, 0, 1'b1, -1);   // NRZ, payload 0x03
      run_frame(3, 4, 3, 1'b0, -1);   // 4-cycle slots, 104-cycle frame
      run_frame(3, 3, 1, 1'b0, -1);   // div lowered 3 -> 1 in the first slot
      run_frame(0, 1, 0, 1'b0, 8);    // ena dropped in DATA

      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         check("quiet_sig", 32'(signal), 32'd0);
         check("quiet_fs", 32'(frame_start), 32'd0);
         check("quiet_busy", 32'(busy), 32'd0);
      end
      check("quiet_count", 32'(count), 32'(m_count));

      // Reset in the middle of DATA.
      div  = 8'd0;
      mode = 1'b0;
      ena  = 1'b1;
      repeat (10) @(negedge clk);
      check("pre_rst_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("arst_sig", 32'(signal), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_fs", 32'(frame_start), 32'd0);
      check("arst_count", 32'(count), 32'd0);
      m_count = 8'd0;
      @(negedge clk);
      check("rst_hold_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      run_frame(0, 1, 0, 1'b0, -1);
      ena = 1'b0;
      @(negedge clk);

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
